matmul_sequencer: RTL and testbench

Initiator for the single-MAC matrix-multiply accumulator: walks DIM×DIM row-major matrices A and B in a synchronous word memory, feeds operand pairs to the MAC, collects each finished dot product and writes C = A·B back to memory. Sits between the control register file (start/base addresses) and the MAC. It owns the MAC's accumulate/clear handshake.

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/matmul_idx_counter.sv | 54 +++++
 rtl/matmul_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer and its MAC.
package matmul_pkg;

    // Operand / accumulator width, common to the sequencer and the MAC.
    localparam int DATA_W = 32;

    // Sequencer states, in the order one dot-product step visits them.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CLR    = 4'd1,
        RD_A   = 4'd2,
        RD_B   = 4'd3,
        CAPB   = 4'd4,
        PULSE  = 4'd5,
        WAIT   = 4'd6,
        SETTLE = 4'd7,
        WRITE  = 4'd8,
        FIN    = 4'd9
    } state_t;

endpackage

// File: rtl/matmul_idx_counter.sv
// Nested i (row) / j (column) / k (inner) loop counters for the matmul walk.
// k advances on i_inc_k; i_next_elem clears k and steps j, carrying into i.
module matmul_idx_counter
    import matmul_pkg::*;
#(
    parameter int DIM   = 4,
    parameter int IDX_W = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc_k,
    input  logic             i_next_elem,
    output logic [IDX_W-1:0] o_i,
    output logic [IDX_W-1:0] o_j,
    output logic [IDX_W-1:0] o_k,
    output logic             o_last_k,
    output logic             o_last_elem
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_k;

    // Loop counters: k innermost, then j, then i (row-major output order).
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_i <= IDX_ZERO;
            r_j <= IDX_ZERO;
            r_k <= IDX_ZERO;
        end else if (i_inc_k) begin
            r_k <= r_k + IDX_ONE;
        end else if (i_next_elem) begin
            r_k <= IDX_ZERO;
            if (r_j == IDX_LAST) begin
                r_j <= IDX_ZERO;
                r_i <= (r_i == IDX_LAST) ? IDX_ZERO : (r_i + IDX_ONE);
            end else begin
                r_j <= r_j + IDX_ONE;
            end
        end
    end

    assign o_i         = r_i;
    assign o_j         = r_j;
    assign o_k         = r_k;
    assign o_last_k    = (r_k == IDX_LAST);
    assign o_last_elem = (r_i == IDX_LAST) && (r_j == IDX_LAST);

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for the single-MAC matrix multiplier: reads A and B operand
// pairs from word memory, drives the MAC clear/accumulate handshake and
// writes each finished dot product of C = A*B back to memory.
// All outputs are registered from the next state, so each output is high
// exactly during the state that owns it.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_a_base,
    input  logic [ADDR_W-1:0] i_b_base,
    input  logic [ADDR_W-1:0] i_c_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [DATA_W-1:0] o_mem_wr_data,
    output logic [DATA_W-1:0] o_a_val_out,
    output logic [DATA_W-1:0] o_b_val_out,
    output logic              o_add_to_accum,
    output logic              o_reset_accum,
    input  logic [DATA_W-1:0] i_accum_in,
    input  logic              i_done_flag_in
);

    localparam int               IDX_W     = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Row-major element address, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  row,
                                                    input logic [IDX_W-1:0]  col);
        return base + ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic              w_clear;
    logic              w_inc_k;
    logic              w_next_elem;
    logic [IDX_W-1:0]  w_i;
    logic [IDX_W-1:0]  w_j;
    logic [IDX_W-1:0]  w_k;
    logic [IDX_W-1:0]  w_k_rd;
    logic              w_last_k;
    logic              w_last_elem;
    logic [ADDR_W-1:0] w_a_addr;
    logic [ADDR_W-1:0] w_b_addr;
    logic [ADDR_W-1:0] w_c_addr;

    logic [ADDR_W-1:0] r_a_base;
    logic [ADDR_W-1:0] r_b_base;
    logic [ADDR_W-1:0] r_c_base;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_a_val;
    logic [DATA_W-1:0] r_b_val;
    logic              r_add;
    logic              r_clr;

    matmul_idx_counter #(
        .DIM   (DIM),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_inc_k     (w_inc_k),
        .i_next_elem (w_next_elem),
        .o_i         (w_i),
        .o_j         (w_j),
        .o_k         (w_k),
        .o_last_k    (w_last_k),
        .o_last_elem (w_last_elem)
    );

    // Entering RD_A from WAIT the k counter steps on the same edge, so the
    // A address must be formed from the incremented k.
    assign w_k_rd   = (r_state == WAIT) ? (w_k + IDX_ONE) : w_k;
    assign w_a_addr = elem_addr(r_a_base, w_i, w_k_rd);
    assign w_b_addr = elem_addr(r_b_base, w_k, w_j);
    assign w_c_addr = elem_addr(r_c_base, w_i, w_j);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and loop-counter control.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_inc_k      = 1'b0;
        w_next_elem  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = CLR;
                    w_clear      = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CLR:   w_next_state = RD_A;
            RD_A:  w_next_state = RD_B;
            RD_B:  w_next_state = CAPB;
            CAPB:  w_next_state = PULSE;
            PULSE: w_next_state = WAIT;
            WAIT: begin
                if (i_done_flag_in) begin
                    if (w_last_k) begin
                        w_next_state = SETTLE;
                    end else begin
                        w_next_state = RD_A;
                        w_inc_k      = 1'b1;
                    end
                end else begin
                    w_next_state = WAIT;
                end
            end
            SETTLE: w_next_state = WRITE;
            WRITE: begin
                w_next_elem  = 1'b1;
                w_next_state = w_last_elem ? FIN : CLR;
            end
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Base addresses are captured only when a job is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_base <= ADDR_ZERO;
            r_b_base <= ADDR_ZERO;
            r_c_base <= ADDR_ZERO;
        end else if ((r_state == IDLE) && i_start) begin
            r_a_base <= i_a_base;
            r_b_base <= i_b_base;
            r_c_base <= i_c_base;
        end
    end

    // Status and MAC control strobes, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_add  <= 1'b0;
            r_clr  <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            r_done <= (w_next_state == FIN);
            r_add  <= (w_next_state == PULSE);
            r_clr  <= (w_next_state == CLR);
        end
    end

    // Memory read and write ports; write data is the MAC result in SETTLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= ADDR_ZERO;
            r_wr_en   <= 1'b0;
            r_wr_addr <= ADDR_ZERO;
            r_wr_data <= DATA_ZERO;
        end else begin
            case (w_next_state)
                RD_A: begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= w_a_addr;
                end
                RD_B: begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= w_b_addr;
                end
                default: begin
                    r_rd_en   <= 1'b0;
                    r_rd_addr <= ADDR_ZERO;
                end
            endcase
            r_wr_en   <= (w_next_state == WRITE);
            r_wr_addr <= (w_next_state == WRITE) ? w_c_addr : ADDR_ZERO;
            r_wr_data <= (w_next_state == WRITE) ? i_accum_in : DATA_ZERO;
        end
    end

    // Operand capture: A data returns in RD_B, B data returns in CAPB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_val <= DATA_ZERO;
            r_b_val <= DATA_ZERO;
        end else begin
            if (r_state == RD_B) begin
                r_a_val <= i_mem_rd_data;
            end
            if (r_state == CAPB) begin
                r_b_val <= i_mem_rd_data;
            end
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_mem_rd_en    = r_rd_en;
    assign o_mem_rd_addr  = r_rd_addr;
    assign o_mem_wr_en    = r_wr_en;
    assign o_mem_wr_addr  = r_wr_addr;
    assign o_mem_wr_data  = r_wr_data;
    assign o_a_val_out    = r_a_val;
    assign o_b_val_out    = r_b_val;
    assign o_add_to_accum = r_add;
    assign o_reset_accum  = r_clr;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer with DIM=2, ADDR_W=8: word memory and an
// edge-detecting MAC around the DUT, plus a matrix-level reference model.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int DIM     = 2;
    localparam int AW      = 8;
    localparam int MEMSZ   = 256;
    localparam int JOB_CYC = 1 + DIM * DIM * (5 * DIM + 3);

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic [AW-1:0] i_a_base, i_b_base, i_c_base;
    logic          o_busy, o_done, o_mem_rd_en, o_mem_wr_en;
    logic [AW-1:0] o_mem_rd_addr, o_mem_wr_addr;
    logic [31:0]   i_mem_rd_data, o_mem_wr_data, o_a_val_out, o_b_val_out;
    logic          o_add_to_accum, o_reset_accum;
    logic [31:0]   i_accum_in;
    logic          i_done_flag_in;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_rst, n_add;

    logic [31:0]   mem     [MEMSZ];
    logic [31:0]   exp_mem [MEMSZ];
    logic          tb_we;
    logic [AW-1:0] tb_wa;
    logic [31:0]   tb_wd;
    logic [AW-1:0] exp_wa[$];
    logic [31:0]   exp_wd[$];
    logic [31:0]   mac_sum;
    logic          mac_prev;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    matmul_sequencer #(.DIM(DIM), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_a_base(i_a_base), .i_b_base(i_b_base), .i_c_base(i_c_base),
        .o_busy(o_busy), .o_done(o_done),
        .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_addr(o_mem_rd_addr), .i_mem_rd_data(i_mem_rd_data),
        .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_addr(o_mem_wr_addr), .o_mem_wr_data(o_mem_wr_data),
        .o_a_val_out(o_a_val_out), .o_b_val_out(o_b_val_out),
        .o_add_to_accum(o_add_to_accum), .o_reset_accum(o_reset_accum),
        .i_accum_in(i_accum_in), .i_done_flag_in(i_done_flag_in)
    );

    // Synchronous memory: one-cycle read latency, DUT write has priority.
    always @(posedge clk) begin
        if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_rd_addr];
        if (o_mem_wr_en) mem[o_mem_wr_addr] <= o_mem_wr_data;
        else if (tb_we) mem[tb_wa] <= tb_wd;
    end

    // MAC: rising edge of add accumulates and acks next cycle; output register lags one cycle.
    always @(posedge clk) begin
        if (reset || o_reset_accum) begin
            mac_sum <= 32'd0; i_accum_in <= 32'd0; i_done_flag_in <= 1'b0; mac_prev <= 1'b0;
        end else begin
            mac_prev <= o_add_to_accum;
            if (o_add_to_accum && !mac_prev) begin
                mac_sum <= mac_sum + o_a_val_out * o_b_val_out;
                i_done_flag_in <= 1'b1;
            end else begin
                i_done_flag_in <= 1'b0;
            end
            i_accum_in <= mac_sum;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Continuous protocol monitor.
    initial begin
        logic          prev_add;
        logic [31:0]   held_a, held_b;
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        prev_add = 1'b0; held_a = 32'd0; held_b = 32'd0;
        forever begin
            @(negedge clk);
            if (o_mem_wr_en) begin
                if (exp_wa.size() == 0) begin
                    chk("unexpected_write_addr", 32'(o_mem_wr_addr), 32'hFFFF_FFFF);
                end else begin
                    ea = exp_wa.pop_front();
                    ed = exp_wd.pop_front();
                    chk("write_addr", 32'(o_mem_wr_addr), 32'(ea));
                    chk("write_data", o_mem_wr_data, ed);
                end
            end
            if (o_reset_accum) n_rst++;
            if (o_add_to_accum) begin
                n_add++;
                chk("add_adjacent", 32'(prev_add), 32'd0);
                chk("add_rst_overlap", 32'(o_reset_accum), 32'd0);
                held_a = o_a_val_out;
                held_b = o_b_val_out;
            end
            if (i_done_flag_in) begin
                chk("a_stable", o_a_val_out, held_a);
                chk("b_stable", o_b_val_out, held_b);
            end
            prev_add = o_add_to_accum;
        end
    end

    task automatic write_word(input logic [AW-1:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d; exp_mem[a] = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic load_mat(input logic [AW-1:0] base, input logic [31:0] v0, v1, v2, v3);
        write_word(base, v0);
        write_word(base + 8'd1, v1);
        write_word(base + 8'd2, v2);
        write_word(base + 8'd3, v3);
    endtask

    task automatic compare_mem();
        for (int a = 0; a < MEMSZ; a++) chk($sformatf("mem_%0h", a), mem[AW'(a)], exp_mem[AW'(a)]);
    endtask

    // One job: reference C from plain matrix arithmetic, then drive and observe.
    task automatic run_job(input logic [AW-1:0] ab, bb, cb, input bit restart, input bit abort);
        logic [31:0]   cexp [DIM][DIM];
        logic [31:0]   s;
        logic [AW-1:0] ca;
        int t, done_t;
        bit fin, done_seen;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                s = 32'd0;
                for (int k = 0; k < DIM; k++)
                    s = s + exp_mem[ab + AW'(i * DIM + k)] * exp_mem[bb + AW'(k * DIM + j)];
                cexp[i][j] = s;
                exp_wa.push_back(cb + AW'(i * DIM + j));
                exp_wd.push_back(s);
            end
        n_rst = 0; n_add = 0;
        i_start = 1'b1; i_a_base = ab; i_b_base = bb; i_c_base = cb;
        t = 0; done_t = 0; fin = 1'b0; done_seen = 1'b0;
        for (int n = 0; n < 300 && !fin; n++) begin
            @(negedge clk);
            if (o_done) begin
                chk("done_cycle", 32'(t), 32'(JOB_CYC));
                done_seen = 1'b1; done_t = t;
            end
            if (t == 1) chk("busy_rise", 32'(o_busy), 32'd1);
            if (done_seen && t == done_t + 1) begin
                chk("busy_fall", 32'(o_busy), 32'd0);
                fin = 1'b1;
            end
            if (abort && t == 20) begin
                chk("rst_ctl", 32'({o_busy, o_done, o_mem_rd_en, o_mem_wr_en, o_add_to_accum, o_reset_accum}), 32'd0);
                chk("rst_addr", 32'({o_mem_rd_addr, o_mem_wr_addr}), 32'd0);
                chk("rst_wdata", o_mem_wr_data, 32'd0);
                chk("rst_a", o_a_val_out, 32'd0);
                chk("rst_b", o_b_val_out, 32'd0);
                fin = 1'b1;
            end
            @(posedge clk); #1;
            t = t + 1;
            if (restart && t == 20) begin
                i_start = 1'b1; i_a_base = 8'h60; i_b_base = 8'h70; i_c_base = 8'hA0;
            end else begin
                i_start = 1'b0;
                i_a_base = AW'($urandom); i_b_base = AW'($urandom); i_c_base = AW'($urandom);
            end
            reset = (abort && t == 19) ? 1'b1 : 1'b0;
            if (abort && t == 19) begin
                exp_wa.delete(); exp_wd.delete();
            end
        end
        chk("job_finished", 32'(fin), 32'd1);
        if (abort) begin
            repeat (40) @(posedge clk);
            #1;
            ca = cb;
            exp_mem[ca] = cexp[0][0];
        end else begin
            chk("reset_accum_pulses", 32'(n_rst), 32'(DIM * DIM));
            chk("add_pulses", 32'(n_add), 32'(DIM * DIM * DIM));
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    ca = cb + AW'(i * DIM + j);
                    exp_mem[ca] = cexp[i][j];
                end
        end
        chk("writes_left", 32'(exp_wa.size()), 32'd0);
        exp_wa.delete(); exp_wd.delete();
        compare_mem();
    endtask

    initial begin
        logic [31:0] known [4];
        logic [AW-1:0] ab, bb, cb;
        reset = 1'b1; i_start = 1'b0; tb_we = 1'b0; tb_wa = 8'd0; tb_wd = 32'd0;
        i_a_base = 8'd0; i_b_base = 8'd0; i_c_base = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'({o_busy, o_done, o_mem_rd_en, o_mem_wr_en, o_add_to_accum, o_reset_accum}), 32'd0);
        chk("reset_data", o_mem_wr_data | o_a_val_out | o_b_val_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int a = 0; a < MEMSZ; a++) write_word(AW'(a), $urandom);

        // Worked example.
        load_mat(8'h00, 32'd1, 32'd2, 32'd3, 32'd4);
        load_mat(8'h10, 32'd5, 32'd6, 32'd7, 32'd8);
        run_job(8'h00, 8'h10, 8'h20, 1'b0, 1'b0);
        known = '{32'd19, 32'd22, 32'd43, 32'd50};
        for (int n = 0; n < 4; n++) chk("example_c", mem[8'h20 + AW'(n)], known[n]);

        // Identity times B.
        load_mat(8'h00, 32'd1, 32'd0, 32'd0, 32'd1);
        load_mat(8'h10, 32'd9, 32'd8, 32'd7, 32'd6);
        run_job(8'h00, 8'h10, 8'h30, 1'b0, 1'b0);
        known = '{32'd9, 32'd8, 32'd7, 32'd6};
        for (int n = 0; n < 4; n++) chk("identity_c", mem[8'h30 + AW'(n)], known[n]);

        // Product overflow wraps to zero.
        load_mat(8'h00, 32'h0001_0000, 32'd0, 32'd0, 32'd0);
        load_mat(8'h10, 32'h0001_0000, 32'd0, 32'd0, 32'd0);
        run_job(8'h00, 8'h10, 8'h40, 1'b0, 1'b0);
        chk("overflow_c00", mem[8'h40], 32'd0);

        // C address wraps past the top of the address space.
        load_mat(8'h10, $urandom, $urandom, $urandom, $urandom);
        load_mat(8'h20, $urandom, $urandom, $urandom, $urandom);
        run_job(8'h10, 8'h20, 8'hFE, 1'b0, 1'b0);

        // Second start mid-job is ignored.
        load_mat(8'h00, $urandom, $urandom, $urandom, $urandom);
        load_mat(8'h10, $urandom, $urandom, $urandom, $urandom);
        run_job(8'h00, 8'h10, 8'h50, 1'b1, 1'b0);

        // Reset during C[0][1], then a fresh job.
        load_mat(8'h00, $urandom, $urandom, $urandom, $urandom);
        load_mat(8'h10, $urandom, $urandom, $urandom, $urandom);
        run_job(8'h00, 8'h10, 8'h58, 1'b0, 1'b1);
        run_job(8'h00, 8'h10, 8'h5C, 1'b0, 1'b0);

        // Random matrices at random non-overlapping bases.
        for (int r = 0; r < 4; r++) begin
            ab = AW'($urandom_range(0, 60));
            bb = AW'($urandom_range(64, 124));
            cb = AW'($urandom_range(128, 252));
            load_mat(ab, $urandom, $urandom, $urandom, $urandom);
            load_mat(bb, $urandom, $urandom, $urandom, $urandom);
            run_job(ab, bb, cb, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
